// File: rtl/fifo_half_writer_pkg.sv
// Shared types and widths for the half-width FIFO writer.
package fifo_half_writer_pkg;

    // Full flit width; the FIFO behind this block is half as wide.
    localparam int unsigned DataWidth = 32;
    localparam int unsigned HalfWidth = DataWidth / 2;

    // Encodings are fixed so FIRST and SECOND share bit 0 (= "holding a flit").
    typedef enum logic [1:0] {
        FhwIdle   = 2'b00,
        FhwFirst  = 2'b01,
        FhwSecond = 2'b11
    } fhw_state_e;

endpackage

// File: rtl/fifo_half_writer.sv
// Splits full-width flits into two half-width words and pushes them into the
// write port of a half-width FIFO, stalling on full. Lives in the FIFO's write
// clock domain; the read-side wrapper reassembles the pairs downstream.
module fifo_half_writer
    import fifo_half_writer_pkg::*;
#(
    parameter bit          HI_FIRST  = 1'b0,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [DataWidth-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [HalfWidth-1:0] fifo_din,
    output logic                 fifo_wr_en,
    input  logic                 fifo_full,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] flit_cnt
);

    fhw_state_e           state_q, state_d;
    logic [DataWidth-1:0] hold_q, hold_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    logic                 handshake;
    logic [HalfWidth-1:0] half_lo, half_hi;
    logic [HalfWidth-1:0] first_half, second_half;

    assign half_lo     = hold_q[HalfWidth-1:0];
    assign half_hi     = hold_q[DataWidth-1:HalfWidth];
    assign first_half  = HI_FIRST ? half_hi : half_lo;
    assign second_half = HI_FIRST ? half_lo : half_hi;

    // Handshake-facing outputs; ready never looks at in_valid.
    always_comb begin
        in_ready   = (state_q == FhwIdle) || ((state_q == FhwSecond) && !fifo_full);
        fifo_wr_en = (state_q != FhwIdle) && !fifo_full;
        busy       = (state_q != FhwIdle);
        flit_cnt   = cnt_q;
        // IDLE also shows the first half; nothing is written then.
        fifo_din   = (state_q == FhwSecond) ? second_half : first_half;
    end

    assign handshake = in_valid && in_ready;

    // Next-state, holding register load and completed-flit count.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        if (handshake) begin
            hold_d = in_data;
        end

        case (state_q)
            FhwIdle: begin
                if (handshake) begin
                    state_d = FhwFirst;
                end
            end
            FhwFirst: begin
                if (!fifo_full) begin
                    state_d = FhwSecond;
                end
            end
            FhwSecond: begin
                if (!fifo_full) begin
                    // Second half goes out now; a new flit may be taken in the same cycle.
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = handshake ? FhwFirst : FhwIdle;
                end
            end
            default: begin
                state_d = FhwIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset; a held flit is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= FhwIdle;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_half_writer.sv
// Bench for fifo_half_writer: three instances (low-half first, high-half first,
// 4-bit counter) share one stimulus; a word scoreboard per instance checks order.
module tb_fifo_half_writer;
    import fifo_half_writer_pkg::*;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b0;
    logic [DataWidth-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 fifo_full = 1'b0;

    logic                 rdy0, rdy1, rdy2;
    logic                 wr0, wr1, wr2;
    logic                 busy0, busy1, busy2;
    logic [HalfWidth-1:0] d0, d1, d2;
    logic [15:0]          cnt0, cnt1;
    logic [3:0]           cnt2;

    int total = 0;
    int bad   = 0;

    logic [HalfWidth-1:0] q0[$], q1[$], q2[$];
    int n0 = 0, n1 = 0, n2 = 0;

    always #5 clk = ~clk;

    fifo_half_writer #(.HI_FIRST(1'b0), .CNT_WIDTH(16)) u_lo (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
        .fifo_din(d0), .fifo_wr_en(wr0), .fifo_full(fifo_full), .busy(busy0), .flit_cnt(cnt0)
    );

    fifo_half_writer #(.HI_FIRST(1'b1), .CNT_WIDTH(16)) u_hi (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
        .fifo_din(d1), .fifo_wr_en(wr1), .fifo_full(fifo_full), .busy(busy1), .flit_cnt(cnt1)
    );

    fifo_half_writer #(.HI_FIRST(1'b0), .CNT_WIDTH(4)) u_c4 (
        .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy2),
        .fifo_din(d2), .fifo_wr_en(wr2), .fifo_full(fifo_full), .busy(busy2), .flit_cnt(cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: pop on every write strobe, push both halves on every handshake.
    always @(negedge clk) begin
        if (rstn) begin
            if (wr0) begin
                if (q0.size() == 0) check_eq("spurious_wr_lo", 32'd1, 32'd0);
                else begin check_eq("word_lo", 32'(d0), 32'(q0.pop_front())); n0++; end
            end
            if (wr1) begin
                if (q1.size() == 0) check_eq("spurious_wr_hi", 32'd1, 32'd0);
                else begin check_eq("word_hi", 32'(d1), 32'(q1.pop_front())); n1++; end
            end
            if (wr2) begin
                if (q2.size() == 0) check_eq("spurious_wr_c4", 32'd1, 32'd0);
                else begin check_eq("word_c4", 32'(d2), 32'(q2.pop_front())); n2++; end
            end
            if (in_valid && rdy0) begin
                q0.push_back(in_data[HalfWidth-1:0]);
                q0.push_back(in_data[DataWidth-1:HalfWidth]);
                q1.push_back(in_data[DataWidth-1:HalfWidth]);
                q1.push_back(in_data[HalfWidth-1:0]);
                q2.push_back(in_data[HalfWidth-1:0]);
                q2.push_back(in_data[DataWidth-1:HalfWidth]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One flit from IDLE with the FIFO never full; checks latency and half order.
    task automatic send_one(input logic [31:0] data);
        in_data  = data;
        in_valid = 1'b1;
        @(negedge clk);
        check_eq("one_ready", 32'(rdy0), 32'd1);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("one_wr1", 32'(wr0), 32'd1);
        check_eq("one_din1_lo", 32'(d0), {16'h0, data[15:0]});
        check_eq("one_din1_hi", 32'(d1), {16'h0, data[31:16]});
        @(negedge clk);
        check_eq("one_wr2", 32'(wr0), 32'd1);
        check_eq("one_din2_lo", 32'(d0), {16'h0, data[31:16]});
        check_eq("one_din2_hi", 32'(d1), {16'h0, data[15:0]});
        @(negedge clk);
        check_eq("one_busy3", 32'(busy0), 32'd0);
        check_eq("one_wr3", 32'(wr0), 32'd0);
        check_eq("one_cnt3", 32'(cnt0), 32'(n0 / 2));
        step();
    endtask

    // Streams n flits with in_valid held; optional pattern checks or full toggling.
    task automatic send_stream(input int n, input bit chk_pat, input bit toggle);
        int  sent = 0;
        int  cyc  = 0;
        bit  hs;
        in_valid = 1'b1;
        in_data  = $urandom;
        while (sent < n && cyc < 400) begin
            @(negedge clk);
            hs = rdy0;
            if (chk_pat) begin
                check_eq("pat_ready", 32'(rdy0), 32'((cyc % 2) == 0));
                check_eq("pat_wr", 32'(wr0), 32'(cyc != 0));
            end
            step();
            cyc++;
            if (hs) begin
                sent++;
                if (sent < n) in_data = $urandom;
                else in_valid = 1'b0;
            end
            if (toggle) fifo_full = ~fifo_full;
        end
        in_valid  = 1'b0;
        fifo_full = 1'b0;
        if (sent < n) check_eq("stream_timeout", 32'(sent), 32'(n));
    endtask

    task automatic drain();
        int c = 0;
        @(negedge clk);
        while (busy0 && c < 50) begin
            @(negedge clk);
            c++;
        end
        if (busy0) check_eq("drain_timeout", 32'(busy0), 32'd0);
        check_eq("drain_cnt_lo", 32'(cnt0), 32'(16'(n0 / 2)));
        check_eq("drain_cnt_c4", 32'(cnt2), 32'(4'(n2 / 2)));
        step();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready", 32'(rdy0), 32'd1);
        check_eq("rst_wr", 32'(wr0), 32'd0);
        check_eq("rst_busy", 32'(busy0), 32'd0);
        check_eq("rst_din", 32'(d0), 32'd0);
        check_eq("rst_cnt", 32'(cnt0), 32'd0);
        step();
        rstn = 1'b1;
        step();

        // Single flits, both orderings
        send_one(32'hAAAA_5555);
        check_eq("cnt_after_one", 32'(cnt0), 32'd1);
        send_one(32'h1234_ABCD);

        // Back-to-back stream of 8 flits
        send_stream(8, 1'b1, 1'b0);
        @(negedge clk);
        check_eq("stream_tail_wr1", 32'(wr0), 32'd1);
        @(negedge clk);
        check_eq("stream_tail_wr2", 32'(wr0), 32'd1);
        @(negedge clk);
        check_eq("stream_idle_wr", 32'(wr0), 32'd0);
        check_eq("stream_idle_busy", 32'(busy0), 32'd0);
        check_eq("stream_cnt", 32'(cnt0), 32'd10);
        step();

        // Full asserted for 5 cycles after the first half is written
        in_data  = 32'hCAFE_BEEF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("stall_first_wr", 32'(wr0), 32'd1);
        check_eq("stall_first_din", 32'(d0), 32'h0000_BEEF);
        step();
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("stall_wr", 32'(wr0), 32'd0);
            check_eq("stall_din", 32'(d0), 32'h0000_CAFE);
            check_eq("stall_ready", 32'(rdy0), 32'd0);
            step();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        check_eq("release_wr", 32'(wr0), 32'd1);
        check_eq("release_din", 32'(d0), 32'h0000_CAFE);
        @(negedge clk);
        check_eq("release_after_wr", 32'(wr0), 32'd0);
        check_eq("release_cnt", 32'(cnt0), 32'd11);
        step();

        // Full toggling every cycle while streaming
        send_stream(6, 1'b0, 1'b1);
        drain();

        // Reset while holding a flit in FIRST with the FIFO full
        in_data  = 32'hDEAD_0001;
        in_valid = 1'b1;
        step();
        in_valid  = 1'b0;
        fifo_full = 1'b1;
        @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy0), 32'd1);
        check_eq("pre_rst_wr", 32'(wr0), 32'd0);
        step();
        rstn = 1'b0;
        step();
        @(negedge clk);
        check_eq("mid_rst_busy", 32'(busy0), 32'd0);
        check_eq("mid_rst_wr", 32'(wr0), 32'd0);
        check_eq("mid_rst_cnt", 32'(cnt0), 32'd0);
        check_eq("mid_rst_ready", 32'(rdy0), 32'd1);
        q0.delete();
        q1.delete();
        q2.delete();
        n0 = 0;
        n1 = 0;
        n2 = 0;
        fifo_full = 1'b0;
        step();
        rstn = 1'b1;
        step();

        // 17 flits through the 4-bit counter
        send_stream(17, 1'b1, 1'b0);
        drain();
        check_eq("wrap_cnt_c4", 32'(cnt2), 32'd1);
        check_eq("wrap_cnt_lo", 32'(cnt0), 32'd17);
        check_eq("wrap_cnt_hi", 32'(cnt1), 32'd17);
        check_eq("wrap_words", 32'(n2), 32'd34);
        check_eq("left_lo", 32'(q0.size()), 32'd0);
        check_eq("left_hi", 32'(q1.size()), 32'd0);
        check_eq("left_c4", 32'(q2.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fifo_half_writer.md
Name: fifo_half_writer

Overview:
- Write-side counterpart of the half-width asynchronous FIFOs in sync_controller.
- Accepts full-width flits (`DATA_WIDTH) on a valid/ready input.
- Splits each flit into two `DATA_WIDTH/2 words and pushes them into the FIFO write port (din/wr_en/full), honouring full.
- Sits in the clk_wr domain in front of the FIFO. The read-side wrapper reassembles the word stream downstream.

Parameters:
- HI_FIRST, 0, half ordering: 0 = bits [`DATA_WIDTH/2-1:0] pushed first, 1 = upper half pushed first.
- CNT_WIDTH, 16, width of the completed-flit counter.
- Data width is `DATA_WIDTH from param.vh and is not a parameter.

Ports:
- clk  in  1  write-domain clock (drives the FIFO clk_wr)
- rstn  in  1  synchronous active-low reset
- in_data  in  `DATA_WIDTH  flit payload
- in_valid  in  1  flit valid
- in_ready  out  1  block can accept a flit this cycle
- fifo_din  out  `DATA_WIDTH/2  half-word to FIFO din
- fifo_wr_en  out  1  FIFO write strobe
- fifo_full  in  1  FIFO full
- busy  out  1  holding register occupied (state != IDLE)
- flit_cnt  out  CNT_WIDTH  flits fully written (both halves)

Behaviour:
- Reset values (rstn sampled low at posedge clk): state=IDLE, hold register=0, flit_cnt=0.
  - Resulting outputs: in_ready=1, fifo_wr_en=0, busy=0, fifo_din=0.
- State register has three states:
  - IDLE: holding register empty.
  - FIRST: flit held, first half pending.
  - SECOND: first half written, second half pending.
- Datapath: one `DATA_WIDTH holding register, loaded only on input handshake (in_valid & in_ready).
- fifo_din (combinational from registers only):
  - FIRST: selects the first half per HI_FIRST.
  - SECOND: selects the second half.
  - IDLE: drives hold register's first half (don't-care; no write).
- fifo_wr_en = (state != IDLE) & ~fifo_full. A word counts as written exactly in cycles where fifo_wr_en=1.
- in_ready = (state==IDLE) | (state==SECOND & ~fifo_full). Not dependent on in_valid.
- Transitions:
  - IDLE: handshake -> FIRST (load). Otherwise stay.
  - FIRST: ~fifo_full -> SECOND. fifo_full -> stay, holding fifo_din and the register stable.
  - SECOND, ~fifo_full, with handshake: write second half, load new flit -> FIRST (back-to-back, no bubble).
  - SECOND, ~fifo_full, no handshake: -> IDLE.
  - SECOND, fifo_full: stay, in_ready=0.
- Latency: flit accepted at edge N. Its first half appears on fifo_din in cycle N+1, written in that cycle if not full.
- Throughput: 1 flit per 2 cycles, sustained, with the FIFO never full.
- flit_cnt increments by 1 on every cycle where state==SECOND & fifo_wr_en. It wraps modulo 2^CNT_WIDTH without saturating.
- in_data is ignored unless in_valid & in_ready. in_valid may drop without a handshake; no protocol error is flagged.
- fifo_full toggling every cycle: each half is written only in cycles with full=0. No word is duplicated or skipped.
- Reset mid-flit (state FIRST or SECOND) returns to IDLE and discards the held flit.
  - If only the first half was written, it is orphaned in the FIFO.
  - This is acceptable only because the FIFO shares rstn and is cleared by the same reset.

Decomposition:
- Add to param.vh: state encodings FHW_IDLE=2'b00, FHW_FIRST=2'b01, FHW_SECOND=2'b11.
- `DATA_WIDTH stays there as today.
- No sub-module is needed; the half-select mux is inline. The block is instantiated next to fifo_PTC_wrapper inside sync_controller.
- Verification harness: connect to AsyncFIFO_RTL plus fifo_PTC_wrapper with both clocks equal, and check reassembled half pairs.

Test Plan:
- Reset, then a single flit 0xAAAA_5555 (32-bit build), HI_FIRST=0, full=0:
  - fifo_din=0x5555 with wr_en=1 in cycle N+1, then 0xAAAA in N+2.
  - flit_cnt=1, state IDLE and busy=0 in N+3.
- Stream 8 flits with in_valid held high, full=0:
  - in_ready pattern 1,0,1,0...; 16 consecutive wr_en pulses with no bubble; flit_cnt=8.
- fifo_full=1 for 5 cycles after the first half is written:
  - wr_en=0 and fifo_din stable at the upper half; in_ready=0.
  - On release, the upper half is written once; no duplicates.
- HI_FIRST=1, flit 0x1234_ABCD:
  - Write order is 0x1234 then 0xABCD.
- rstn=0 asserted while in FIRST with full=1:
  - Next cycle state IDLE, busy=0, wr_en=0, flit_cnt=0, in_ready=1.
- CNT_WIDTH=4, 17 flits:
  - flit_cnt reads 1 after wrap; all 34 halves pass through the FIFO chain in order.
